// File: rtl/led_sequencer_if.sv
// Command and LED-bank bus of the LED sequencer: command handshake in,
// abort, and the registered LED drive plus status flags out.
interface led_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [2:0] cmd_rate;
  logic [7:0] cmd_pattern;
  logic [3:0] cmd_repeat;
  logic       abort;
  logic [7:0] led;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_mode, cmd_rate, cmd_pattern, cmd_repeat, abort,
    input  cmd_ready, led, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_rate, cmd_pattern, cmd_repeat, abort,
    output cmd_ready, led, busy, done
  );
endinterface

// File: rtl/led_sequencer.sv
// Command-driven LED pattern controller. Owns the prescaler and the 8-bit
// LED bank; runs OFF/STATIC/BLINK/ROTATE commands with optional repeat
// count, supports preemption from RUN, abort, and a one-cycle done pulse.
module led_sequencer #(
  parameter int CNT_W      = 26,
  parameter int SHIFT_BASE = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  led_sequencer_if.slave  bus
);

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_prescaler;
  logic [1:0]       r_mode;
  logic [2:0]       r_rate;
  logic [7:0]       r_pattern;
  logic [3:0]       r_repeat;
  logic [3:0]       r_remaining;
  logic [7:0]       r_led;

  logic             w_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_mask;
  logic             w_tick;
  logic             w_last_tick;

  // Ready is purely a function of state and abort, so it reads 1 in reset.
  assign w_ready     = ((r_state == ST_IDLE) || (r_state == ST_RUN)) && !bus.abort;
  assign w_accept    = bus.cmd_valid && w_ready;
  assign w_mask      = (CNT_ONE << (SHIFT_BASE + 32'(r_rate))) - CNT_ONE;
  assign w_tick      = (r_state == ST_RUN) && (r_prescaler == w_mask);
  assign w_last_tick = w_tick && (r_repeat != 4'd0) && (r_remaining == 4'd1);

  assign bus.cmd_ready = w_ready;
  assign bus.led       = r_led;
  assign bus.busy      = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: abort beats accept, accept beats tick.
  always_comb begin
    w_next_state = r_state;
    if (bus.abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_next_state = ST_LOAD;
        ST_LOAD: begin
          if ((r_mode == MODE_OFF) || (r_mode == MODE_STATIC)) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            w_next_state = ST_LOAD;
          end else if (w_last_tick) begin
            w_next_state = ST_DONE;
          end
        end
        ST_DONE: w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Command latch, prescaler, repeat counter and LED bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescaler <= '0;
      r_mode      <= 2'd0;
      r_rate      <= 3'd0;
      r_pattern   <= 8'h00;
      r_repeat    <= 4'd0;
      r_remaining <= 4'd0;
      r_led       <= 8'h00;
    end else if (bus.abort) begin
      r_led <= 8'h00;
    end else begin
      if (w_accept) begin
        r_mode    <= bus.cmd_mode;
        r_rate    <= bus.cmd_rate;
        r_pattern <= bus.cmd_pattern;
        r_repeat  <= bus.cmd_repeat;
      end
      case (r_state)
        ST_LOAD: begin
          r_prescaler <= '0;
          r_remaining <= r_repeat;
          r_led       <= (r_mode == MODE_OFF) ? 8'h00 : r_pattern;
        end
        ST_RUN: begin
          if (!w_accept) begin
            if (w_tick) begin
              r_prescaler <= '0;
              if (r_mode == MODE_BLINK) begin
                r_led <= r_led ^ r_pattern;
              end else begin
                r_led <= {r_led[6:0], r_led[7]};
              end
              if ((r_repeat != 4'd0) && (r_remaining > 4'd1)) begin
                r_remaining <= r_remaining - 4'd1;
              end
            end else begin
              r_prescaler <= r_prescaler + CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with SHIFT_BASE = 2: reset, STATIC,
// BLINK with repeat, ROTATE with preemption on a tick, abort, async reset.
module tb_led_sequencer;

  logic clk;
  logic rst_n;
  int   totalChecks;
  int   badChecks;
  int   doneCount;
  int   doneBase;

  led_sequencer_if busIf ();

  led_sequencer #(
    .CNT_W      (26),
    .SHIFT_BASE (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf.slave)
  );

  // 10-unit clock; inputs are driven and outputs sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses so "no done" claims can be checked across a scenario.
  always @(posedge clk) begin
    if (busIf.done === 1'b1) doneCount++;
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the command/abort inputs.
  task automatic applyStimulus(input logic valid, input logic [1:0] mode,
                               input logic [2:0] rate, input logic [7:0] pattern,
                               input logic [3:0] rpt, input logic abortIn);
    busIf.cmd_valid   = valid;
    busIf.cmd_mode    = mode;
    busIf.cmd_rate    = rate;
    busIf.cmd_pattern = pattern;
    busIf.cmd_repeat  = rpt;
    busIf.abort       = abortIn;
  endtask

  // Present a command for one edge; returns at the falling edge of the LOAD cycle.
  task automatic sendCmd(input logic [1:0] mode, input logic [2:0] rate,
                         input logic [7:0] pattern, input logic [3:0] rpt);
    applyStimulus(1'b1, mode, rate, pattern, rpt, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 3'd0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    doneCount   = 0;
    rst_n       = 1'b1;
    applyStimulus(1'b0, 2'd0, 3'd0, 8'h00, 4'd0, 1'b0);

    // 1. Reset asserted mid-cycle, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_led",   32'(busIf.led),       32'h00);
    checkOutput("rst_busy",  32'(busIf.busy),      32'h0);
    checkOutput("rst_done",  32'(busIf.done),      32'h0);
    checkOutput("rst_ready", 32'(busIf.cmd_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(1);

    // 2. STATIC 0xA5.
    sendCmd(2'd1, 3'd0, 8'hA5, 4'd0);
    checkOutput("st_load_busy",  32'(busIf.busy),      32'h1);
    checkOutput("st_load_ready", 32'(busIf.cmd_ready), 32'h0);
    waitCycles(1);
    checkOutput("st_led",        32'(busIf.led),  32'hA5);
    checkOutput("st_done",       32'(busIf.done), 32'h1);
    checkOutput("st_done_busy",  32'(busIf.busy), 32'h0);
    waitCycles(1);
    checkOutput("st_done_end",   32'(busIf.done), 32'h0);
    checkOutput("st_idle_led",   32'(busIf.led),  32'hA5);

    // 3. BLINK rate 0, pattern 0x0F, repeat 3: toggles every 4 cycles.
    sendCmd(2'd2, 3'd0, 8'h0F, 4'd3);
    waitCycles(1);
    checkOutput("bl_init", 32'(busIf.led), 32'h0F);
    waitCycles(3);
    checkOutput("bl_hold", 32'(busIf.led), 32'h0F);
    waitCycles(1);
    checkOutput("bl_t1",   32'(busIf.led), 32'h00);
    waitCycles(4);
    checkOutput("bl_t2",   32'(busIf.led), 32'h0F);
    checkOutput("bl_t2_done", 32'(busIf.done), 32'h0);
    waitCycles(3);
    checkOutput("bl_pre_busy", 32'(busIf.busy), 32'h1);
    waitCycles(1);
    checkOutput("bl_t3",      32'(busIf.led),  32'h00);
    checkOutput("bl_done",    32'(busIf.done), 32'h1);
    checkOutput("bl_busy",    32'(busIf.busy), 32'h0);
    waitCycles(1);
    checkOutput("bl_done_end", 32'(busIf.done), 32'h0);

    // 4. ROTATE rate 1, pattern 0x81, repeat 0; preempt with STATIC on a tick.
    doneBase = doneCount;
    sendCmd(2'd3, 3'd1, 8'h81, 4'd0);
    waitCycles(1);
    checkOutput("ro_init", 32'(busIf.led), 32'h81);
    waitCycles(8);
    checkOutput("ro_r1",   32'(busIf.led), 32'h03);
    waitCycles(8);
    checkOutput("ro_r2",   32'(busIf.led), 32'h06);
    waitCycles(8);
    checkOutput("ro_r3",   32'(busIf.led), 32'h0C);
    checkOutput("ro_busy", 32'(busIf.busy), 32'h1);
    checkOutput("ro_nodone", 32'(doneCount - doneBase), 32'd0);
    waitCycles(7);
    sendCmd(2'd1, 3'd0, 8'h3C, 4'd0);
    checkOutput("ro_pre_hold", 32'(busIf.led),  32'h0C);
    checkOutput("ro_pre_busy", 32'(busIf.busy), 32'h1);
    waitCycles(1);
    checkOutput("ro_pre_led",  32'(busIf.led),  32'h3C);
    checkOutput("ro_pre_done", 32'(busIf.done), 32'h1);
    waitCycles(1);
    checkOutput("ro_done_cnt", 32'(doneCount - doneBase), 32'd1);

    // 5. Abort during RUN together with a STATIC 0xFF command.
    sendCmd(2'd2, 3'd0, 8'h55, 4'd0);
    waitCycles(3);
    checkOutput("ab_run_led", 32'(busIf.led), 32'h55);
    doneBase = doneCount;
    applyStimulus(1'b1, 2'd1, 3'd0, 8'hFF, 4'd0, 1'b1);
    #1;
    checkOutput("ab_ready", 32'(busIf.cmd_ready), 32'h0);
    @(negedge clk);
    checkOutput("ab_led",  32'(busIf.led),  32'h00);
    checkOutput("ab_busy", 32'(busIf.busy), 32'h0);
    applyStimulus(1'b0, 2'd0, 3'd0, 8'h00, 4'd0, 1'b0);
    waitCycles(1);
    checkOutput("ab_idle_led",   32'(busIf.led),       32'h00);
    checkOutput("ab_idle_ready", 32'(busIf.cmd_ready), 32'h1);
    checkOutput("ab_nodone",     32'(doneCount - doneBase), 32'd0);

    // 6. Async reset mid-RUN, then a normal STATIC completion.
    sendCmd(2'd2, 3'd0, 8'hF0, 4'd5);
    waitCycles(3);
    checkOutput("ar_run_led", 32'(busIf.led), 32'hF0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_led",   32'(busIf.led),       32'h00);
    checkOutput("ar_busy",  32'(busIf.busy),      32'h0);
    checkOutput("ar_ready", 32'(busIf.cmd_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(1);
    sendCmd(2'd1, 3'd0, 8'h11, 4'd0);
    checkOutput("ar_load_busy", 32'(busIf.busy), 32'h1);
    waitCycles(1);
    checkOutput("ar_st_led",  32'(busIf.led),  32'h11);
    checkOutput("ar_st_done", 32'(busIf.done), 32'h1);
    waitCycles(1);
    checkOutput("ar_st_end",  32'(busIf.done), 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Command-driven LED pattern controller that owns the free-running prescaler counter and the 8-bit LED output bank of the top-level tile. Requesters submit one command at a time over a valid/ready handshake: mode, rate, pattern and repeat count. The block sequences the LEDs from prescaler ticks, supports preemption and abort, and reports completion with a one-cycle pulse.

## Interface
- CNT_W, 26, prescaler width in bits; requires SHIFT_BASE + 7 < CNT_W
- SHIFT_BASE, 18, log2 of the tick period at rate 0; benches override to 2
- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_mode  in  2  0 OFF, 1 STATIC, 2 BLINK, 3 ROTATE
- cmd_rate  in  3  tick period = 2^(SHIFT_BASE + cmd_rate) cycles
- cmd_pattern  in  8  LED pattern
- cmd_repeat  in  4  ticks to run before completion; 0 = run forever
- abort  in  1  synchronous stop; blanks the LEDs
- led  out  8  LED drive (registered)
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset enters IDLE.
- cmd_ready = (state == IDLE || state == RUN) && !abort. It is combinational and reads 1 during reset.
- On accept, latch mode, rate, pattern and repeat, then go to LOAD. This applies from IDLE and from RUN (preemption). Accept overrides any tick in the same cycle.
- LOAD takes one cycle and cmd_ready = 0.
  - Clear the prescaler to 0 and set remaining = repeat.
  - Set led: OFF gives 0x00; STATIC, BLINK and ROTATE give the pattern.
  - Next state: OFF or STATIC go to DONE; BLINK or ROTATE go to RUN.
- RUN:
  - The prescaler increments every cycle.
  - tick = (prescaler == 2^(SHIFT_BASE+rate) − 1). On tick the prescaler wraps to 0.
  - On tick, BLINK sets led <= led ^ pattern. ROTATE rotates led left by 1 (bit 7 moves to bit 0).
  - If repeat != 0, remaining decrements on each tick. A tick with remaining == 1 goes to DONE.
  - If repeat == 0, RUN continues until preempted or aborted.
- DONE: done = 1 for exactly one cycle, busy = 0, led holds, then go to IDLE.
- IDLE: led holds its last value.
- abort in any state: next state IDLE and led <= 0x00. No done pulse. A pending cmd_valid is not accepted. abort has priority over accept and over tick.
- Arithmetic:
  - The prescaler compares against a mask of SHIFT_BASE+rate low ones and never overflows CNT_W.
  - remaining is 4-bit and never decrements below 1 while in RUN.

## Timing
- Reset values: led = 0x00, busy = 0, done = 0, state IDLE, prescaler 0, latched command 0.
- Accept at edge E0 puts the block in LOAD for the cycle after E0. The led initial value is visible after E1.
- STATIC/OFF: done is high in the cycle after E1. busy is high for exactly 1 cycle.
- BLINK/ROTATE: the first LED update is visible 2^(SHIFT_BASE+rate) cycles after E1. Subsequent updates follow with the same period.
- With repeat = N, done rises the cycle after the N-th tick edge. busy falls at the same edge.
- Preempting in RUN at edge Ep: the old pattern holds during LOAD. The new initial value is visible after Ep+1, and the prescaler restarts from 0.
- abort sampled at edge Ea: led = 0x00 and state IDLE are visible after Ea. cmd_ready = 0 in the abort cycle.
- rst_n low forces all registers to reset values immediately, independent of clk, from any state.

## Test plan
All scenarios use SHIFT_BASE = 2.
1. Reset: assert rst_n low mid-cycle -> led = 0x00, busy = 0, done = 0, cmd_ready = 1 without a clock edge.
2. STATIC 0xA5 accepted -> led = 0xA5 one cycle after accept; busy high for 1 cycle; done high for 1 cycle in the following cycle; led stays 0xA5 in IDLE.
3. BLINK, rate 0, pattern 0x0F, repeat 3 -> led 0x0F, then 0x00, 0x0F, 0x00, changing every 4 cycles; done pulses once after the third toggle; final led = 0x00.
4. ROTATE, rate 1, pattern 0x81, repeat 0 -> led 0x81, 0x03, 0x06, 0x0C every 8 cycles with no done. Then issue STATIC 0x3C on a tick cycle -> no rotation that cycle; led = 0x3C one cycle after accept; done pulses.
5. abort asserted during RUN together with cmd_valid (STATIC 0xFF) -> cmd_ready = 0, led = 0x00 next cycle, state IDLE, no done; 0xFF never appears.
6. Async reset asserted mid-RUN (BLINK repeat 5) -> led and busy clear immediately. After release, accepting STATIC 0x11 gives normal 2-cycle completion.
